// File: rtl/staircase_seq_gen.sv
// Staircase sequence generator: emits runs 1..n (or n..1) for n = 1..lim,
// one term per enabled clock, with run/sequence boundary flags.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_RUN  | presenting terms; each enabled edge consumes the current one
// S_DONE | one-shot sequence finished; outputs forced to 0 until clr/rst
module staircase_seq_gen #(
  parameter int WIDTH    = 3,
  parameter bit WRAP_DEF = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] lim,
  input  logic             dir,
  input  logic             wrap,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] run_len,
  output logic             run_first,
  output logic             run_last,
  output logic             seq_done,
  output logic             busy
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] lim_q;
  logic             dir_q;
  logic             wrap_q;
  logic             seq_done_q;

  logic [WIDTH-1:0] lim_eff;
  logic             at_run_end;
  logic             at_seq_end;

  // A zero limit would make an empty sequence; treat it as a single run of 1.
  assign lim_eff    = (lim == '0) ? ONE : lim;
  assign at_run_end = dir_q ? (cnt_q == ONE) : (cnt_q == n_q);
  assign at_seq_end = at_run_end && (n_q >= lim_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RUN;
      n_q        <= ONE;
      cnt_q      <= ONE;
      lim_q      <= '1;
      dir_q      <= 1'b0;
      wrap_q     <= WRAP_DEF;
      seq_done_q <= 1'b0;
    end else if (clr) begin
      state_q    <= S_RUN;
      n_q        <= ONE;
      cnt_q      <= ONE;
      lim_q      <= lim_eff;
      dir_q      <= dir;
      wrap_q     <= wrap;
      seq_done_q <= 1'b0;
    end else if (en && (state_q == S_RUN)) begin
      seq_done_q <= at_seq_end;
      if (at_seq_end) begin
        n_q   <= ONE;
        cnt_q <= ONE;
        if (wrap_q) begin
          lim_q  <= lim_eff;
          dir_q  <= dir;
          wrap_q <= wrap;
        end else begin
          state_q <= S_DONE;
        end
      end else if (at_run_end) begin
        // n < lim_q here, so n+1 cannot overflow even at the maximum limit.
        n_q   <= n_q + ONE;
        cnt_q <= dir_q ? (n_q + ONE) : ONE;
      end else begin
        cnt_q <= dir_q ? (cnt_q - ONE) : (cnt_q + ONE);
      end
    end else begin
      seq_done_q <= 1'b0;
    end
  end

  always_comb begin
    busy      = (state_q == S_RUN);
    count     = busy ? cnt_q : '0;
    run_len   = busy ? n_q : '0;
    run_first = busy && (cnt_q == (dir_q ? n_q : ONE));
    run_last  = busy && (cnt_q == (dir_q ? ONE : n_q));
    seq_done  = seq_done_q;
  end

endmodule

// File: tb/tb_staircase_seq_gen.sv
// Self-checking bench for staircase_seq_gen: expected terms are generated by
// nested loops into a scoreboard queue and popped as the DUT presents terms.
module tb_staircase_seq_gen;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         clr;
  logic [W-1:0] lim;
  logic         dir;
  logic         wrap;
  logic [W-1:0] count;
  logic [W-1:0] run_len;
  logic         run_first;
  logic         run_last;
  logic         seq_done;
  logic         busy;

  staircase_seq_gen #(.WIDTH(W), .WRAP_DEF(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .lim(lim), .dir(dir), .wrap(wrap),
    .count(count), .run_len(run_len), .run_first(run_first), .run_last(run_last),
    .seq_done(seq_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // {count, run_len, run_first, run_last, seq_done, busy}
  logic [9:0] obs;
  assign obs = {count, run_len, run_first, run_last, seq_done, busy};

  logic [9:0] sb[$];
  logic [9:0] exp_v;
  int n_cmp = 0;
  int n_bad = 0;

  // Push one whole sequence of effective limit l; done_first marks the seq_done
  // pulse expected alongside its first term (previous sequence just ended).
  function automatic void push_seq(int l, bit d, bit done_first);
    int c;
    bit df;
    df = done_first;
    for (int n = 1; n <= l; n++) begin
      for (int k = 1; k <= n; k++) begin
        c = d ? (n - k + 1) : k;
        sb.push_back({3'(c), 3'(n), (k == 1), (k == n), df, 1'b1});
        df = 1'b0;
      end
    end
  endfunction

  task automatic tick(input bit e);
    en = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_seq(input logic [W-1:0] l, input bit d, input bit w);
    lim = l; dir = d; wrap = w; clr = 1'b1;
    tick(1'b0);
    clr = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b0; clr = 1'b0; lim = '0; dir = 1'b0; wrap = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs !== {3'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL reset_state: got %b want %b", obs, {3'd1, 3'd1, 4'b1101});
    end
    rst = 1'b1;
    tick(1'b0);
    n_cmp++;
    if (obs !== {3'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL reset_release_hold: got %b want %b", obs, {3'd1, 3'd1, 4'b1101});
    end
  endtask

  task automatic test_ascending;
    start_seq(3'd4, 1'b0, 1'b1);
    push_seq(4, 1'b0, 1'b0);
    push_seq(4, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL asc_term %0d: got %b want %b", i, obs, exp_v);
      end
      tick(1'b1);
    end
  endtask

  task automatic test_descending;
    start_seq(3'd4, 1'b1, 1'b1);
    push_seq(4, 1'b1, 1'b0);
    push_seq(4, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL desc_term %0d: got %b want %b", i, obs, exp_v);
      end
      tick(1'b1);
    end
  endtask

  task automatic test_one_shot;
    start_seq(3'd3, 1'b0, 1'b0);
    push_seq(3, 1'b0, 1'b0);
    sb.push_back(10'b000_000_0010);
    repeat (3) sb.push_back(10'b000_000_0000);
    for (int i = 0; i < 10; i++) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL oneshot_term %0d: got %b want %b", i, obs, exp_v);
      end
      tick(1'b1);
    end
  endtask

  task automatic test_limits;
    start_seq(3'd0, 1'b0, 1'b1);
    push_seq(1, 1'b0, 1'b0);
    repeat (4) push_seq(1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL lim0_term %0d: got %b want %b", i, obs, exp_v);
      end
      tick(1'b1);
    end
    start_seq(3'd7, 1'b0, 1'b1);
    push_seq(7, 1'b0, 1'b0);
    push_seq(7, 1'b0, 1'b1);
    for (int i = 0; i < 29; i++) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL lim7_term %0d: got %b want %b", i, obs, exp_v);
      end
      tick(1'b1);
    end
  endtask

  task automatic test_enable_and_clr;
    start_seq(3'd4, 1'b0, 1'b1);
    push_seq(4, 1'b0, 1'b0);
    push_seq(4, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) begin
      // Terms 3 and 4 are presented for two extra cycles with en low.
      if (i == 3 || i == 4) begin
        for (int h = 0; h < 2; h++) begin
          n_cmp++;
          if (obs !== sb[0]) begin
            n_bad++; $display("FAIL en_hold %0d/%0d: got %b want %b", i, h, obs, sb[0]);
          end
          tick(1'b0);
        end
      end
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL en_term %0d: got %b want %b", i, obs, exp_v);
      end
      tick(1'b1);
    end
    clr = 1'b1;
    tick(1'b1);
    clr = 1'b0;
    sb.delete();
    push_seq(4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL clr_en_term %0d: got %b want %b", i, obs, exp_v);
      end
      tick(1'b1);
    end
  endtask

  task automatic test_midrun_changes;
    start_seq(3'd4, 1'b0, 1'b1);
    push_seq(4, 1'b0, 1'b0);
    push_seq(2, 1'b0, 1'b1);
    push_seq(2, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      if (i == 3) begin
        lim = 3'd2; dir = 1'b0;
      end
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL midlim_term %0d: got %b want %b", i, obs, exp_v);
      end
      tick(1'b1);
    end
    // Now mid-run (count=2); assert reset between clock edges.
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== {3'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL async_rst: got %b want %b", obs, {3'd1, 3'd1, 4'b1101});
    end
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    push_seq(7, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL post_rst_term %0d: got %b want %b", i, obs, exp_v);
      end
      tick(1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_one_shot();
    test_limits();
    test_enable_and_clr();
    test_midrun_changes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
